// File: rtl/fifo_stream_reader.sv
// Drains a fifo read port into a valid/ready stream with sop/eop framing every PKT_LEN beats.
// A 2-entry output buffer hides the fifo read latency so the stream can run at full rate.
module fifo_stream_reader #(
    parameter int unsigned DWIDTH    = 4,
    parameter bit          SHOWAHEAD = 1'b1,
    parameter int unsigned PKT_LEN   = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sop_o,
    output logic              eop_o
);

    localparam int unsigned CntW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(PKT_LEN - 1);

    logic [1:0]        occ_q, occ_d;
    logic              inf_q, inf_d;
    logic [DWIDTH-1:0] head_q, head_d;
    logic [DWIDTH-1:0] tail_q, tail_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              pop;
    logic              push;
    logic              rdreq;
    logic [2:0]        level;

    always_comb begin
        pop   = (occ_q != 2'd0) && ready_i;
        // Words owned by this block after this cycle's pop: buffered plus in flight.
        level = {1'b0, occ_q} + {2'b00, inf_q} - {2'b00, pop};
        rdreq = !fifo_empty_i && !srst_i && (level < 3'd2);
        push  = SHOWAHEAD ? rdreq : inf_q;
        inf_d = SHOWAHEAD ? 1'b0 : rdreq;

        head_d = head_q;
        tail_d = tail_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = fifo_q_i;
                end else begin
                    tail_d = fifo_q_i;
                end
            end
            2'b01: begin
                head_d = (occ_q == 2'd2) ? tail_q : '0;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = fifo_q_i;
                end else begin
                    head_d = fifo_q_i;
                end
            end
            default: ;
        endcase

        occ_d = occ_q + {1'b0, push} - {1'b0, pop};

        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            occ_q  <= 2'd0;
            inf_q  <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            inf_q  <= inf_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign fifo_rdreq_o = rdreq;
    assign valid_o      = (occ_q != 2'd0);
    assign data_o       = head_q;
    assign sop_o        = valid_o && (cnt_q == '0);
    assign eop_o        = valid_o && (cnt_q == CntMax);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Drives a show-ahead and a registered-read instance from fifo models sharing one write log,
// scoring every transferred beat against the log in write order.
module tb_fifo_stream_reader;

    localparam int PKT = 8;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       rdy = 1'b0;
    logic       empty0, empty1;
    logic [3:0] q0, q1;
    logic       rdreq0, rdreq1;
    logic [3:0] data0, data1;
    logic       valid0, valid1, sop0, sop1, eop0, eop1;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DWIDTH(4), .SHOWAHEAD(1'b1), .PKT_LEN(PKT)) u_sa1 (
        .clk_i(clk), .srst_i(srst), .fifo_q_i(q0), .fifo_empty_i(empty0),
        .fifo_rdreq_o(rdreq0), .data_o(data0), .valid_o(valid0), .ready_i(rdy),
        .sop_o(sop0), .eop_o(eop0)
    );

    fifo_stream_reader #(.DWIDTH(4), .SHOWAHEAD(1'b0), .PKT_LEN(PKT)) u_sa0 (
        .clk_i(clk), .srst_i(srst), .fifo_q_i(q1), .fifo_empty_i(empty1),
        .fifo_rdreq_o(rdreq1), .data_o(data1), .valid_o(valid1), .ready_i(rdy),
        .sop_o(sop1), .eop_o(eop1)
    );

    // Scoreboard: every word written to the fifos, in order; per-DUT read/transfer pointers.
    logic [3:0] sb[$];
    int         fp[2];
    int         xi[2];
    int         bc[2];
    int         frd[2];
    int         fv[2];
    int         tl[2];
    logic       pv[2], ps[2], pe[2];
    logic [3:0] pd[2];
    logic       pr = 1'b0;
    logic       prst = 1'b0;
    logic [3:0] qreg1 = 4'h0;
    int         cyc_n = 0;
    int         total = 0;
    int         bad = 0;

    task automatic cmp(input string tag, input int id, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, id, obs, exp);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        qreg1 = 4'h0;
        for (int i = 0; i < 2; i++) begin
            fp[i]  = 0;
            xi[i]  = 0;
            bc[i]  = 0;
            frd[i] = -1;
            fv[i]  = -1;
            tl[i]  = -1;
            pv[i]  = 1'b0;
        end
    endtask

    task automatic chk(input int id, input logic rd, input logic v, input logic [3:0] d,
                       input logic s, input logic e, input logic emp);
        if (srst) begin
            cmp("rdreq_in_reset", id, 32'(rd), 0);
        end else begin
            if (prst) cmp("valid_after_reset", id, 32'(v), 0);
            if (rd) cmp("rdreq_while_empty", id, 32'(emp), 0);
            if (!v) begin
                cmp("data_idle", id, 32'(d), 0);
                cmp("sop_idle", id, 32'(s), 0);
                cmp("eop_idle", id, 32'(e), 0);
            end
            if (pv[id] && !pr && !prst) begin
                cmp("hold_valid", id, 32'(v), 1);
                cmp("hold_data", id, 32'(d), 32'(pd[id]));
                cmp("hold_sop", id, 32'(s), 32'(ps[id]));
                cmp("hold_eop", id, 32'(e), 32'(pe[id]));
            end
            cmp("owned_le_2", id, 32'((fp[id] - xi[id]) <= 2), 1);
            if (rd && frd[id] < 0) frd[id] = cyc_n;
            if (v && fv[id] < 0) fv[id] = cyc_n;
            if (v && rdy) begin
                cmp("beat_available", id, 32'(xi[id] < sb.size()), 1);
                if (xi[id] < sb.size()) cmp("data", id, 32'(d), 32'(sb[xi[id]]));
                cmp("sop", id, 32'(s), 32'(bc[id] == 0));
                cmp("eop", id, 32'(e), 32'(bc[id] == PKT - 1));
                xi[id]++;
                bc[id] = (bc[id] + 1) % PKT;
                if (xi[id] == 16) tl[id] = cyc_n;
            end
        end
        pv[id] = v;
        pd[id] = d;
        ps[id] = s;
        pe[id] = e;
    endtask

    task automatic cyc(input bit wr, input logic [3:0] wd, input bit rd_y, input bit rst);
        @(negedge clk);
        srst   = rst;
        rdy    = rd_y;
        empty0 = (fp[0] >= sb.size());
        q0     = empty0 ? 4'h0 : sb[fp[0]];
        empty1 = (fp[1] >= sb.size());
        q1     = qreg1;
        #1;
        chk(0, rdreq0, valid0, data0, sop0, eop0, empty0);
        chk(1, rdreq1, valid1, data1, sop1, eop1, empty1);
        if (rst) begin
            clear_model();
        end else begin
            if (rdreq0 && !empty0) fp[0]++;
            if (rdreq1 && !empty1) begin
                qreg1 = sb[fp[1]];
                fp[1]++;
            end
            if (wr) sb.push_back(wd);
        end
        prst = rst;
        pr   = rd_y;
        cyc_n++;
    endtask

    initial begin
        int written;
        clear_model();

        // Reset with a non-empty fifo.
        for (int i = 0; i < 4; i++) sb.push_back(4'(i + 5));
        cyc(1'b0, 4'h0, 1'b1, 1'b1);
        cyc(1'b0, 4'h0, 1'b1, 1'b1);

        // Streaming 1..16 at full rate.
        for (int i = 1; i <= 16; i++) sb.push_back(4'(i));
        for (int i = 0; i < 25; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cmp("latency_rd_to_valid", 0, 32'(fv[0] - frd[0]), 1);
        cmp("latency_rd_to_valid", 1, 32'(fv[1] - frd[1]), 2);
        cmp("no_bubbles", 0, 32'(tl[0] - fv[0]), 15);
        cmp("no_bubbles", 1, 32'(tl[1] - fv[1]), 15);

        // Backpressure for 5 cycles mid-stream.
        for (int i = 0; i < 16; i++) sb.push_back(4'(15 - i));
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0);
        cmp("stall_owned", 0, 32'(fp[0] - xi[0]), 2);
        cmp("stall_owned", 1, 32'(fp[1] - xi[1]), 2);
        for (int i = 0; i < 25; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cmp("bp_all_delivered", 0, 32'(xi[0]), 32'(sb.size()));
        cmp("bp_all_delivered", 1, 32'(xi[1]), 32'(sb.size()));

        // Fifo runs dry after beat 3 of a packet, then refills.
        for (int i = 0; i < 3; i++) sb.push_back(4'(i + 3));
        for (int i = 0; i < 14; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cmp("dry_valid_low", 0, 32'(pv[0]), 0);
        cmp("dry_valid_low", 1, 32'(pv[1]), 0);
        cmp("dry_beat_held", 0, 32'(bc[0]), 3);
        cmp("dry_beat_held", 1, 32'(bc[1]), 3);
        for (int i = 0; i < 5; i++) sb.push_back(4'(i + 9));
        for (int i = 0; i < 12; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cmp("resume_pkt_done", 0, 32'(bc[0]), 0);
        cmp("resume_pkt_done", 1, 32'(bc[1]), 0);

        // Reset while the buffer is full.
        for (int i = 0; i < 6; i++) sb.push_back(4'(i + 1));
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0);
        cmp("full_before_reset", 0, 32'(fp[0] - xi[0]), 2);
        cmp("full_before_reset", 1, 32'(fp[1] - xi[1]), 2);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sb.push_back(4'(i + 10));
        for (int i = 0; i < 8; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cmp("post_reset_delivered", 0, 32'(xi[0]), 4);
        cmp("post_reset_delivered", 1, 32'(xi[1]), 4);

        // Random writes and random ready, 1000 words.
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        written = 0;
        for (int n = 0; n < 20000; n++) begin
            bit wr;
            if (written == 1000 && xi[0] == 1000 && xi[1] == 1000) break;
            wr = (written < 1000) && ($urandom_range(0, 9) < 6);
            if (wr) written++;
            cyc(wr, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
        end
        cmp("random_delivered", 0, 32'(xi[0]), 1000);
        cmp("random_delivered", 1, 32'(xi[1]), 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
